// File: rtl/ch_buf.sv
// ch_buf: per-channel source/destination FWFT buffers with word-count tracker.
// Define CH_BUF_ERR_EN to enable sticky overflow/underflow flags on err0.
module ch_buf_fifo #(
    parameter int DW = 64,
    parameter int AW = 9
) (
    input  logic          clk,
    input  logic          clr,
    input  logic          push,
    input  logic          pop,
    input  logic [DW:0]   wdata,
    output logic [DW:0]   rdata,
    output logic [AW:0]   cnt
);
    localparam int DEPTH = 2**AW;

    logic [DW:0]   mem [DEPTH];
    logic [AW-1:0] wp, rp;
    logic          full, empty, pop_ok, acc;

    assign full   = cnt[AW];
    assign empty  = (cnt == '0);
    assign pop_ok = pop & ~empty & ~clr;
    // a full FIFO always has a word to pop, so push+pop is safe
    assign acc    = push & (~full | pop_ok) & ~clr;
    assign rdata  = mem[rp];

    always_ff @(posedge clk) begin
        if (acc)
            mem[wp] <= wdata;
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            wp  <= '0;
            rp  <= '0;
            cnt <= '0;
        end else begin
            if (acc)
                wp <= wp + 1'b1;
            if (pop_ok)
                rp <= rp + 1'b1;
            if (acc & ~pop_ok)
                cnt <= cnt + 1'b1;
            else if (~acc & pop_ok)
                cnt <= cnt - 1'b1;
        end
    end
endmodule

module ch_buf #(
    parameter int DW        = 64,
    parameter int AW        = 9,
    parameter int AF_MARGIN = 4,
    parameter int AE_LVL    = 2,
    parameter int BURST     = (2**AW)/2
) (
    input  logic          wb_clk_i,
    input  logic          wb_rstn_i,
    input  logic          m_reset0,
    input  logic [23:0]   dc0,
    input  logic          dc_ld0,
    input  logic          ss_xfer0,
    input  logic          ss_last0,
    input  logic [DW-1:0] wbs_dat_o0,
    output logic          ss_start0,
    output logic          ss_stop0,
    output logic          ss_end0,
    input  logic          m_src_getn0,
    output logic [DW-1:0] m_src0,
    output logic          m_src_last0,
    output logic          m_src_empty0,
    output logic          m_src_almost_empty0,
    input  logic          m_dst_putn0,
    input  logic [DW-1:0] m_dst0,
    input  logic          m_dst_last0,
    output logic          m_dst_full0,
    output logic          m_dst_almost_full0,
    input  logic          m_endn0,
    input  logic          ss_xfer1,
    output logic [DW-1:0] wbs_dat_i1,
    output logic          ss_start1,
    output logic          ss_stop1,
    output logic          ss_end1,
    output logic [1:0]    err0
);
    localparam int DEPTH = 2**AW;
    localparam logic [AW:0] AF_C = (AW+1)'(DEPTH-AF_MARGIN);
    localparam logic [AW:0] AE_C = (AW+1)'(AE_LVL);
    localparam logic [AW:0] ST_C = (AW+1)'(DEPTH-BURST);
    localparam logic [AW:0] BU_C = (AW+1)'(BURST);

    typedef enum logic [1:0] {D_IDLE, D_RUN, D_FLUSH} d_state_t;

    logic          clr;
    logic [AW:0]   cnt_s, cnt_d;
    logic [DW:0]   src_rd, dst_rd;
    logic          full_s, empty_d, head_last;
    logic          src_acc, src_last;
    logic [23:0]   src_rem;
    logic          armed, ended;
    d_state_t      d_state;

    assign clr = ~wb_rstn_i | m_reset0;

    assign full_s   = cnt_s[AW];
    assign src_acc  = ss_xfer0 & (~full_s | ~m_src_getn0) & ~clr;
    assign src_last = ss_last0 | (armed & (src_rem == 24'd1));

    ch_buf_fifo #(.DW(DW), .AW(AW)) u_src (
        .clk   (wb_clk_i),
        .clr   (clr),
        .push  (ss_xfer0),
        .pop   (~m_src_getn0),
        .wdata ({src_last, wbs_dat_o0}),
        .rdata (src_rd),
        .cnt   (cnt_s)
    );

    ch_buf_fifo #(.DW(DW), .AW(AW)) u_dst (
        .clk   (wb_clk_i),
        .clr   (clr),
        .push  (~m_dst_putn0),
        .pop   (ss_xfer1),
        .wdata ({m_dst_last0, m_dst0}),
        .rdata (dst_rd),
        .cnt   (cnt_d)
    );

    assign m_src0              = src_rd[DW-1:0];
    assign m_src_last0         = src_rd[DW];
    assign m_src_empty0        = (cnt_s == '0);
    assign m_src_almost_empty0 = (cnt_s <= AE_C);
    assign ss_stop0            = (cnt_s >= AF_C);
    assign ss_start0           = (cnt_s <= ST_C) & ~ended;
    assign ss_end0             = ended;

    assign wbs_dat_i1         = dst_rd[DW-1:0];
    assign head_last          = dst_rd[DW];
    assign empty_d            = (cnt_d == '0);
    assign m_dst_full0        = cnt_d[AW];
    assign m_dst_almost_full0 = (cnt_d >= AF_C);
    assign ss_stop1           = m_dst_almost_full0;
    assign ss_end1            = head_last & ~empty_d;

    always_ff @(posedge wb_clk_i) begin
        if (clr) begin
            src_rem <= '0;
            armed   <= 1'b0;
            ended   <= 1'b0;
        end else if (dc_ld0) begin
            src_rem <= dc0;
            armed   <= (dc0 != '0);
            ended   <= (dc0 == '0);
        end else if (src_acc & armed) begin
            src_rem <= src_rem - 24'd1;
            if (src_rem == 24'd1) begin
                armed <= 1'b0;
                ended <= 1'b1;
            end
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (clr) begin
            d_state <= D_IDLE;
        end else begin
            unique case (d_state)
                D_IDLE:
                    if (cnt_d >= BU_C)
                        d_state <= D_RUN;
                    else if (~m_endn0 & ~empty_d)
                        d_state <= D_FLUSH;
                D_RUN:
                    if (~m_endn0)
                        d_state <= D_FLUSH;
                    else if (cnt_d < BU_C)
                        d_state <= D_IDLE;
                D_FLUSH:
                    if (empty_d & m_endn0)
                        d_state <= D_IDLE;
                default:
                    d_state <= D_IDLE;
            endcase
        end
    end

    assign ss_start1 = (d_state == D_RUN) |
                       ((d_state == D_FLUSH) & ~empty_d);

`ifdef CH_BUF_ERR_EN
    logic [1:0] err_q;
    logic       ovf, unf;

    assign ovf = (ss_xfer0 & full_s & m_src_getn0) |
                 (~m_dst_putn0 & m_dst_full0 & ~ss_xfer1);
    assign unf = (~m_src_getn0 & m_src_empty0) |
                 (ss_xfer1 & empty_d);

    // sticky across channel clear; only the global reset wipes it
    always_ff @(posedge wb_clk_i) begin
        if (!wb_rstn_i)
            err_q <= '0;
        else if (!m_reset0)
            err_q <= err_q | {unf, ovf};
    end

    assign err0 = err_q;
`else
    assign err0 = '0;
`endif
endmodule

// File: tb/tb_ch_buf.sv
// tb_ch_buf: scoreboard bench for ch_buf (DEPTH 16, AF_MARGIN 2, BURST 8).
// Expected err0 follows CH_BUF_ERR_EN.
module tb_ch_buf;
`ifdef CH_BUF_ERR_EN
    localparam bit ERR_ON = 1'b1;
`else
    localparam bit ERR_ON = 1'b0;
`endif

    logic        wb_clk_i = 0;
    logic        wb_rstn_i, m_reset0;
    logic [23:0] dc0;
    logic        dc_ld0, ss_xfer0, ss_last0;
    logic [15:0] wbs_dat_o0;
    logic        ss_start0, ss_stop0, ss_end0;
    logic        m_src_getn0;
    logic [15:0] m_src0;
    logic        m_src_last0, m_src_empty0, m_src_almost_empty0;
    logic        m_dst_putn0;
    logic [15:0] m_dst0;
    logic        m_dst_last0, m_dst_full0, m_dst_almost_full0;
    logic        m_endn0, ss_xfer1;
    logic [15:0] wbs_dat_i1;
    logic        ss_start1, ss_stop1, ss_end1;
    logic [1:0]  err0;

    ch_buf #(.DW(16), .AW(4), .AF_MARGIN(2), .AE_LVL(2), .BURST(8)) dut (
        .wb_clk_i(wb_clk_i), .wb_rstn_i(wb_rstn_i), .m_reset0(m_reset0),
        .dc0(dc0), .dc_ld0(dc_ld0), .ss_xfer0(ss_xfer0), .ss_last0(ss_last0),
        .wbs_dat_o0(wbs_dat_o0), .ss_start0(ss_start0), .ss_stop0(ss_stop0),
        .ss_end0(ss_end0), .m_src_getn0(m_src_getn0), .m_src0(m_src0),
        .m_src_last0(m_src_last0), .m_src_empty0(m_src_empty0),
        .m_src_almost_empty0(m_src_almost_empty0), .m_dst_putn0(m_dst_putn0),
        .m_dst0(m_dst0), .m_dst_last0(m_dst_last0), .m_dst_full0(m_dst_full0),
        .m_dst_almost_full0(m_dst_almost_full0), .m_endn0(m_endn0),
        .ss_xfer1(ss_xfer1), .wbs_dat_i1(wbs_dat_i1), .ss_start1(ss_start1),
        .ss_stop1(ss_stop1), .ss_end1(ss_end1), .err0(err0)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    int          n_vec = 0;
    int          n_bad = 0;
    logic [16:0] src_q[$];
    logic [16:0] dst_q[$];
    int          ms_cnt = 0, md_cnt = 0;
    int          m_rem = 0;
    bit          m_armed = 0, m_ended = 0;
    logic [1:0]  m_err = 0;
    logic [15:0] sd = 16'h0, dd = 16'h8000;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic flags();
        chk("s_empty", m_src_empty0, ms_cnt == 0);
        chk("s_aempty", m_src_almost_empty0, ms_cnt <= 2);
        chk("ss_stop0", ss_stop0, ms_cnt >= 14);
        chk("ss_start0", ss_start0, ms_cnt <= 8 && !m_ended);
        chk("ss_end0", ss_end0, m_ended);
        chk("d_full", m_dst_full0, md_cnt == 16);
        chk("d_afull", m_dst_almost_full0, md_cnt >= 14);
        chk("ss_stop1", ss_stop1, md_cnt >= 14);
        chk("ss_end1", ss_end1, md_cnt > 0 ? dst_q[0][16] : 1'b0);
        chk("err0", err0, ERR_ON ? m_err : 2'b00);
        if (ms_cnt > 0)
            chk("s_head", {m_src_last0, m_src0}, src_q[0]);
        if (md_cnt > 0)
            chk("d_head", wbs_dat_i1, dst_q[0][15:0]);
    endtask

    task automatic idle_in();
        ss_xfer0 = 0; ss_last0 = 0; m_src_getn0 = 1; m_dst_putn0 = 1;
        m_dst_last0 = 0; ss_xfer1 = 0; m_reset0 = 0; dc_ld0 = 0;
    endtask

    task automatic cyc(input bit ps, input bit pp, input bit pd,
                       input bit pq, input bit clr, input bit sl,
                       input bit dl);
        bit s_pop, d_pop, s_acc, d_acc, lst;
        logic [16:0] e;
        ss_xfer0 = ps; ss_last0 = sl; wbs_dat_o0 = sd; m_src_getn0 = !pp;
        m_dst_putn0 = !pd; m_dst0 = dd; m_dst_last0 = dl; ss_xfer1 = pq;
        m_reset0 = clr;
        s_pop = !clr && pp && ms_cnt > 0;
        d_pop = !clr && pq && md_cnt > 0;
        s_acc = !clr && ps && (ms_cnt < 16 || s_pop);
        d_acc = !clr && pd && (md_cnt < 16 || d_pop);
        if (s_pop) begin
            e = src_q.pop_front();
            chk("pop_src", {m_src_last0, m_src0}, e);
        end
        if (d_pop) begin
            e = dst_q.pop_front();
            chk("pop_dat", wbs_dat_i1, e[15:0]);
            chk("pop_end1", ss_end1, e[16]);
        end
        if (!clr) begin
            if ((ps && !s_acc) || (pd && !d_acc)) m_err[0] = 1;
            if ((pp && ms_cnt == 0) || (pq && md_cnt == 0)) m_err[1] = 1;
        end
        if (s_acc) begin
            lst = sl || (m_armed && m_rem == 1);
            src_q.push_back({lst, sd});
            if (m_armed) begin
                m_rem--;
                if (m_rem == 0) begin m_armed = 0; m_ended = 1; end
            end
        end
        if (d_acc) dst_q.push_back({dl, dd});
        ms_cnt += (s_acc ? 1 : 0) - (s_pop ? 1 : 0);
        md_cnt += (d_acc ? 1 : 0) - (d_pop ? 1 : 0);
        if (clr) begin
            src_q.delete(); dst_q.delete();
            ms_cnt = 0; md_cnt = 0; m_rem = 0; m_armed = 0; m_ended = 0;
        end
        @(posedge wb_clk_i); #1;
        if (s_acc) sd++;
        if (d_acc) dd++;
        idle_in();
        flags();
    endtask

    task automatic load(input int v);
        idle_in();
        dc0 = 24'(v); dc_ld0 = 1;
        m_rem = v; m_armed = (v != 0); m_ended = (v == 0);
        @(posedge wb_clk_i); #1;
        dc_ld0 = 0;
        flags();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        // reset with everything else active
        wb_rstn_i = 0; m_reset0 = 0; dc0 = 24'd5; dc_ld0 = 1;
        ss_xfer0 = 1; ss_last0 = 1; wbs_dat_o0 = 16'hdead;
        m_src_getn0 = 0; m_dst_putn0 = 0; m_dst0 = 16'hbeef;
        m_dst_last0 = 1; m_endn0 = 0; ss_xfer1 = 1;
        repeat (3) @(posedge wb_clk_i);
        #1;
        chk("rst_s_empty", m_src_empty0, 1);
        chk("rst_s_aempty", m_src_almost_empty0, 1);
        chk("rst_start0", ss_start0, 1);
        chk("rst_stop0", ss_stop0, 0);
        chk("rst_end0", ss_end0, 0);
        chk("rst_d_full", m_dst_full0, 0);
        chk("rst_d_afull", m_dst_almost_full0, 0);
        chk("rst_start1", ss_start1, 0);
        chk("rst_stop1", ss_stop1, 0);
        chk("rst_end1", ss_end1, 0);
        chk("rst_err", err0, 0);
        wb_rstn_i = 1; m_endn0 = 1; idle_in();
        cyc(0, 0, 0, 0, 0, 0, 0);

        // fill source, overflow, drain in order
        for (int i = 0; i < 16; i++) cyc(1, 0, 0, 0, 0, 0, 0);
        chk("fill_stop0", ss_stop0, 1);
        cyc(1, 0, 0, 0, 0, 0, 0);
        chk("ovf_err", err0, ERR_ON ? 2'b01 : 2'b00);
        for (int i = 0; i < 16; i++) cyc(0, 1, 0, 0, 0, 0, 0);

        // word-count tracker
        load(5);
        for (int i = 0; i < 5; i++) cyc(1, 0, 0, 0, 0, 0, 0);
        chk("trk_end0", ss_end0, 1);
        chk("trk_last", m_src_last0, 0);
        cyc(1, 0, 0, 0, 0, 0, 0);
        chk("trk_start0", ss_start0, 0);
        for (int i = 0; i < 6; i++) cyc(0, 1, 0, 0, 0, 0, 0);
        load(0);
        chk("trk_zero", ss_end0, 1);
        load(3);
        chk("trk_rearm", ss_start0, 1);
        cyc(0, 0, 0, 0, 1, 0, 0);

        // destination drain FSM
        for (int i = 0; i < 7; i++) cyc(0, 0, 1, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0);
        chk("fsm_idle7", ss_start1, 0);
        cyc(0, 0, 1, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0);
        chk("fsm_run", ss_start1, 1);
        for (int i = 0; i < 5; i++) cyc(0, 0, 0, 1, 0, 0, 0);
        chk("fsm_back_idle", ss_start1, 0);
        m_endn0 = 0;
        cyc(0, 0, 1, 0, 0, 0, 1);
        chk("fsm_flush", ss_start1, 1);
        for (int i = 0; i < 4; i++) cyc(0, 0, 0, 1, 0, 0, 0);
        chk("fsm_flush_empty", ss_start1, 0);
        m_endn0 = 1;
        cyc(0, 0, 1, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0);
        chk("fsm_idle_after", ss_start1, 0);
        cyc(0, 0, 0, 1, 0, 0, 0);

        // full + simultaneous push/pop across pointer wrap
        for (int i = 0; i < 16; i++) cyc(1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 40; i++) cyc(1, 1, 0, 0, 0, 0, 0);
        chk("wrap_err", err0, ERR_ON ? 2'b01 : 2'b00);
        for (int i = 0; i < 16; i++) cyc(0, 1, 0, 0, 0, 0, 0);

        // clear mid-transfer with a same-cycle push
        for (int i = 0; i < 6; i++) cyc(1, 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 1, 0, 0);
        chk("clr_empty", m_src_empty0, 1);
        chk("clr_err_kept", err0, ERR_ON ? 2'b01 : 2'b00);
        cyc(1, 0, 0, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0, 0, 0);

        // pop from empty source
        cyc(0, 1, 0, 0, 0, 0, 0);
        chk("unf_err", err0, ERR_ON ? 2'b11 : 2'b00);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/ch_buf.md
# ch_buf

Parametrised bidirectional channel buffer for one ssdma channel, clocked by `wb_clk_i`. It has two independent first-word-fall-through FIFOs:
- **source FIFO:** Wishbone stream side to engine module.
- **destination FIFO:** engine module to Wishbone stream side.

It adds a word-count tracker that ends source transfers, a three-state destination drain FSM, and configurable thresholds. The block sits between the Wishbone stream master and the processing module of a channel, with one instance per channel.

## Interface
Parameters:
- `DW`, 64: data width, both directions.
- `AW`, 9: address width; `DEPTH = 2**AW` words per FIFO.
- `AF_MARGIN`, 4: almost-full asserts at `cnt >= DEPTH-AF_MARGIN`.
- `AE_LVL`, 2: almost-empty asserts at `cnt <= AE_LVL`.
- `BURST`, `DEPTH/2`: start threshold, both directions.

Ports:
- `wb_clk_i` in 1: the single clock.
- `wb_rstn_i` in 1: reset; synchronous, active-low.
- `m_reset0` in 1: synchronous channel clear; active-high.
- `dc0` in 24: transfer length in words.
- `dc_ld0` in 1: pulse; loads `dc0` into `src_rem` and arms the tracker.
- `ss_xfer0` in 1: push to source FIFO.
- `ss_last0` in 1: last flag with the push.
- `wbs_dat_o0` in DW: push data.
- `ss_start0` out 1: request to start fetching.
- `ss_stop0` out 1: stop fetching.
- `ss_end0` out 1: programmed count exhausted.
- `m_src_getn0` in 1: pop source, active-low.
- `m_src0` out DW: head data.
- `m_src_last0` out 1: head last flag.
- `m_src_empty0` out 1: source FIFO empty.
- `m_src_almost_empty0` out 1: source FIFO almost empty.
- `m_dst_putn0` in 1: push destination, active-low.
- `m_dst0` in DW: destination push data.
- `m_dst_last0` in 1: destination last flag.
- `m_dst_full0` out 1: destination FIFO full.
- `m_dst_almost_full0` out 1: destination FIFO almost full.
- `m_endn0` in 1: module finished, active-low; requests flush.
- `ss_xfer1` in 1: pop destination.
- `wbs_dat_i1` out DW: destination head data.
- `ss_start1` out 1: request to start writing back.
- `ss_stop1` out 1: stop writing back.
- `ss_end1` out 1: destination head word is last.
- `err0` out 2: sticky error flags; `[0]` overflow, `[1]` underflow.

## Operation
**FIFO storage and occupancy**
- Each FIFO holds `DW+1` bits per entry (data plus last flag).
- Pointers are AW bits and wrap modulo DEPTH.
- Occupancy `cnt` is AW+1 bits, range 0..DEPTH.
- `full` means `cnt == DEPTH`; `empty` means `cnt == 0`.

**Push and pop rules**
- A push when full is dropped.
- A push with a simultaneous pop when full is accepted; `cnt` is unchanged.
- A pop when empty is ignored, including when a push happens in the same cycle.

**Source flags**
- `ss_stop0 = cnt_s >= DEPTH-AF_MARGIN`.
- `ss_start0 = cnt_s <= DEPTH-BURST`, and is also forced low once the tracker has ended.

**Source word-count tracker**
- `dc_ld0` sets `src_rem = dc0`, `armed = 1`, `ended = 0`.
- Each accepted push while armed decrements `src_rem`.
- The stored last flag is `ss_last0 | (armed & src_rem == 1)`.
- When `src_rem` reaches 0: `ended = 1`, `ss_end0 = 1` and held until the next `dc_ld0` or clear.
- `dc_ld0` with `dc0 = 0` sets `ended` immediately.

**Destination drain FSM**
- **D_IDLE:**
  - `ss_start1 = 0`.
  - Go to D_RUN when `cnt_d >= BURST`.
  - Else go to D_FLUSH when `!m_endn0 & !empty_d`.
- **D_RUN:**
  - `ss_start1 = 1`.
  - Go to D_IDLE when `cnt_d < BURST` and `m_endn0` is high.
  - Go to D_FLUSH when `!m_endn0`.
- **D_FLUSH:**
  - `ss_start1 = !empty_d`.
  - Go to D_IDLE on `empty_d & m_endn0`.
- Other destination outputs: `ss_stop1 = m_dst_almost_full0`; `ss_end1 = head_last & !empty_d`.

**Clear and reset**
- `m_reset0` clears pointers, counts, tracker and FSM, and sets the FSM to D_IDLE.
- Clear has priority over same-cycle push, pop and `dc_ld0`.
- `err0` survives `m_reset0`; only `wb_rstn_i` clears it.
- `wb_rstn_i` low has the same effect as clear, plus `err0 = 0`.

## Timing
**Reset values**
- 1: `m_src_empty0`, `m_src_almost_empty0`, `ss_start0`.
- 0: all other outputs.
- Data outputs are don't-care when their FIFO is empty.

**Latency**
- Data is FWFT: a word pushed at edge N appears on the head at N+1 when the FIFO was empty.
- Pop advances the head at the pop edge.
- All flags derive from the registered `cnt` and settle one cycle after the causing edge.
- `ss_end0` asserts the cycle after the final push.
- FSM outputs are registered state decodes; a transition at edge N is visible at N+1.

**Flow control**
- Upstream must stop within `AF_MARGIN-1` cycles of `ss_stop0`.

## Configuration
Macro `CH_BUF_ERR_EN`:
- **Defined:**
  - `err0[0]` sets on a push dropped while full (either FIFO).
  - `err0[1]` sets on a pop ignored while empty (either FIFO).
- **Undefined:**
  - `err0` is tied to 0 and the error logic is absent.
  - Drop and ignore behaviour is unchanged.

## Test plan
Settings: `AW=4` (DEPTH 16), `AF_MARGIN=2`, `BURST=8`, `AE_LVL=2`.
- **Reset:** hold `wb_rstn_i` low 3 cycles with other inputs active -> all outputs at reset values; `cnt` 0.
- **Fill to full:** 16 source pushes of 0..15, no pops -> `ss_stop0` from `cnt=14`, `ss_start0` low from `cnt=9`. A 17th push is dropped and sets `err0=2'b01` with `CH_BUF_ERR_EN`. Popping then returns 0..15 in order.
- **Count tracker:** `dc_ld0` with `dc0=5`, then 5 pushes -> 5th stored word has `m_src_last0=1`; `ss_end0` high the next cycle; `ss_start0` low until the next `dc_ld0`.
- **Destination FSM:** 7 `m_dst_putn0` pushes -> stays D_IDLE (`ss_start1=0`). 8th push -> `ss_start1=1`. Then `m_endn0` low with 3 words left -> D_FLUSH, `ss_end1` on the word pushed with `m_dst_last0`, back to D_IDLE when empty.
- **Wrap and full simultaneous:** 40 cycles of simultaneous push and pop at `cnt=16` -> `cnt` stays 16, data order is preserved across pointer wrap, no error set.
- **Clear mid-transfer:** `m_reset0` at `cnt_s=6` together with a push -> `cnt_s=0` next cycle, push discarded, `err0` retained.
